// File: rtl/mem_sram_resp.sv
// Block-RAM-backed burst responder for the memory-controller request/data interface.
// Optional range checking: define MEM_SRAM_RESP_RANGECHK_EN to flag bursts that run past the SRAM end.

module mem_sram_resp_lane #(
   parameter int AW = 10
) (
   input  logic          clock,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [2**AW];
   logic [7:0] rd_q;

   always_ff @(posedge clock) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rd_q <= mem_q[addr_i];
   end

   assign rdata_o = rd_q;

endmodule

module mem_sram_resp #(
   parameter int WIDTH        = 32,
   parameter int MASKS        = WIDTH/8,
   parameter int ADDRS        = 32,
   parameter int MEM_ID_WIDTH = 4,
   parameter int BURST_LEN    = 4,
   parameter int SRAM_WORDS   = 1024
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mem_wrreq_i,
   output logic                    mem_wrack_o,
   output logic                    mem_wrerr_o,
   input  logic                    mem_wrlst_i,
   input  logic [MEM_ID_WIDTH-1:0] mem_wrtid_i,
   input  logic [ADDRS-1:0]        mem_wradr_i,
   input  logic                    wr_valid_i,
   output logic                    wr_ready_o,
   input  logic                    wr_last_i,
   input  logic [MASKS-1:0]        wr_mask_i,
   input  logic [WIDTH-1:0]        wr_data_i,
   input  logic                    mem_rdreq_i,
   output logic                    mem_rdack_o,
   output logic                    mem_rderr_o,
   input  logic                    mem_rdlst_i,
   input  logic [MEM_ID_WIDTH-1:0] mem_rdtid_i,
   input  logic [ADDRS-1:0]        mem_rdadr_i,
   output logic                    rd_valid_o,
   input  logic                    rd_ready_i,
   output logic                    rd_last_o,
   output logic [WIDTH-1:0]        rd_data_o
);

   localparam int OFFW = $clog2(MASKS);
   localparam int AW   = $clog2(SRAM_WORDS);
   localparam int CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } rd_beat_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ADDRS-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             rr_q, rr_d;
   logic             grant_wr, grant_rd;
   logic             wr_fire, rd_issue;
   logic             last_beat;
   logic [ADDRS-1:0] wr_idx, rd_idx, beat_idx;
   logic             wr_err, rd_err;
   logic [AW-1:0]    sram_addr;
   logic [MASKS-1:0] lane_we;
   logic [MASKS-1:0][7:0] sram_rdata;

   logic             inflight_q, infl_last_q, infl_err_q;
   rd_beat_t         fifo_q [4];
   logic [1:0]       wptr_q, rptr_q;
   logic [2:0]       fcnt_q;
   logic             fifo_empty, push, pop, fifo_pop;
   logic             room;
   rd_beat_t         infl_beat, head;

   assign wr_idx    = mem_wradr_i >> OFFW;
   assign rd_idx    = mem_rdadr_i >> OFFW;
   assign last_beat = (cnt_q == CW'(BURST_LEN-1));
   assign beat_idx  = idx_q + ADDRS'(cnt_q);
   assign sram_addr = beat_idx[AW-1:0];

`ifdef MEM_SRAM_RESP_RANGECHK_EN
   function automatic logic range_err(input logic [ADDRS-1:0] idx);
      return ({1'b0, idx} + (ADDRS+1)'(BURST_LEN)) > (ADDRS+1)'(SRAM_WORDS);
   endfunction
   assign wr_err = range_err(wr_idx);
   assign rd_err = range_err(rd_idx);
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   // Occupancy counts the beat in the SRAM output register so at most 4 are ever buffered.
   assign room = (4'(fcnt_q) + 4'(inflight_q)) < 4'd4;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      err_d    = err_q;
      rr_d     = rr_q;
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      wr_fire  = 1'b0;
      rd_issue = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!reset) begin
               if (mem_wrreq_i && (!mem_rdreq_i || !rr_q)) grant_wr = 1'b1;
               else if (mem_rdreq_i)                        grant_rd = 1'b1;
            end
            if (grant_wr) begin
               state_d = S_WRITE;
               idx_d   = wr_idx;
               err_d   = wr_err;
               cnt_d   = '0;
               rr_d    = ~rr_q;
            end else if (grant_rd) begin
               state_d = S_READ;
               idx_d   = rd_idx;
               err_d   = rd_err;
               cnt_d   = '0;
               rr_d    = ~rr_q;
            end
         end
         S_WRITE: begin
            wr_fire = wr_valid_i & ~reset;
            if (wr_fire) begin
               cnt_d = cnt_q + CW'(1);
               if (last_beat) state_d = S_IDLE;
            end
         end
         S_READ: begin
            rd_issue = room & ~reset;
            if (rd_issue) begin
               cnt_d = cnt_q + CW'(1);
               if (last_beat) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_wrack_o = grant_wr;
   assign mem_wrerr_o = grant_wr & wr_err;
   assign mem_rdack_o = grant_rd;
   assign mem_rderr_o = grant_rd & rd_err;
   assign wr_ready_o  = (state_q == S_WRITE);

   assign lane_we = wr_fire ? (wr_mask_i & {MASKS{~err_q}}) : '0;

   for (genvar l = 0; l < MASKS; l++) begin : g_lane
      mem_sram_resp_lane #(.AW(AW)) u_lane (
         .clock   (clock),
         .we_i    (lane_we[l]),
         .re_i    (rd_issue),
         .addr_i  (sram_addr),
         .wdata_i (wr_data_i[8*l +: 8]),
         .rdata_o (sram_rdata[l])
      );
   end

   // An empty FIFO is bypassed by the SRAM output so first data appears one cycle after issue.
   assign infl_beat.last = infl_last_q;
   assign infl_beat.data = infl_err_q ? '0 : WIDTH'(sram_rdata);

   assign fifo_empty = (fcnt_q == 3'd0);
   assign head       = fifo_empty ? infl_beat : fifo_q[rptr_q];
   assign rd_valid_o = ~fifo_empty | inflight_q;
   assign rd_data_o  = rd_valid_o ? head.data : '0;
   assign rd_last_o  = rd_valid_o & head.last;
   assign pop        = rd_valid_o & rd_ready_i;
   assign fifo_pop   = pop & ~fifo_empty;
   assign push       = inflight_q & ~(fifo_empty & rd_ready_i);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rr_q        <= 1'b0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         infl_err_q  <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rr_q        <= rr_d;
         inflight_q  <= rd_issue;
         infl_last_q <= last_beat;
         infl_err_q  <= err_q;
         if (push)     wptr_q <= wptr_q + 2'd1;
         if (fifo_pop) rptr_q <= rptr_q + 2'd1;
         fcnt_q      <= fcnt_q + 3'(push) - 3'(fifo_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_q[wptr_q] <= infl_beat;
   end

   logic unused_ok;
   assign unused_ok = ^{mem_wrlst_i, mem_wrtid_i, mem_rdlst_i, mem_rdtid_i, wr_last_i, beat_idx};

endmodule

// File: tb/tb_mem_sram_resp.sv
// Directed bench for mem_sram_resp: arbitration, masked writes, backpressure, range/wrap, mid-burst reset.
// Expectations follow MEM_SRAM_RESP_RANGECHK_EN when it is defined for the build.

module tb_mem_sram_resp;

   logic        clock, reset;
   logic        mem_wrreq_i, mem_wrack_o, mem_wrerr_o, mem_wrlst_i;
   logic [3:0]  mem_wrtid_i;
   logic [31:0] mem_wradr_i;
   logic        wr_valid_i, wr_ready_o, wr_last_i;
   logic [3:0]  wr_mask_i;
   logic [31:0] wr_data_i;
   logic        mem_rdreq_i, mem_rdack_o, mem_rderr_o, mem_rdlst_i;
   logic [3:0]  mem_rdtid_i;
   logic [31:0] mem_rdadr_i;
   logic        rd_valid_o, rd_ready_i, rd_last_o;
   logic [31:0] rd_data_o;

   int n_run, n_fail;
   int n_wrack, n_rdack, n_both;

   mem_sram_resp dut (
      .clock(clock), .reset(reset),
      .mem_wrreq_i(mem_wrreq_i), .mem_wrack_o(mem_wrack_o), .mem_wrerr_o(mem_wrerr_o),
      .mem_wrlst_i(mem_wrlst_i), .mem_wrtid_i(mem_wrtid_i), .mem_wradr_i(mem_wradr_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_last_i(wr_last_i),
      .wr_mask_i(wr_mask_i), .wr_data_i(wr_data_i),
      .mem_rdreq_i(mem_rdreq_i), .mem_rdack_o(mem_rdack_o), .mem_rderr_o(mem_rderr_o),
      .mem_rdlst_i(mem_rdlst_i), .mem_rdtid_i(mem_rdtid_i), .mem_rdadr_i(mem_rdadr_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o),
      .rd_data_o(rd_data_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mem_wrack_o) n_wrack++;
      if (mem_rdack_o) n_rdack++;
      if (mem_wrack_o && mem_rdack_o) n_both++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   // Holds a write request until acked (bounded); returns at the first cycle after the ack.
   task automatic wait_wrack(input string tag, input logic [31:0] adr, input logic exp_err);
      bit got = 0;
      mem_wrreq_i = 1'b1;
      mem_wradr_i = adr;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (mem_wrack_o) begin
            got = 1;
            chk({tag, " wrerr"}, mem_wrerr_o, exp_err);
         end
         step();
      end
      if (!got) chk({tag, " wrack timeout"}, 0, 1);
      mem_wrreq_i = 1'b0;
   endtask

   task automatic wait_rdack(input string tag, input logic [31:0] adr, input logic exp_err);
      bit got = 0;
      mem_rdreq_i = 1'b1;
      mem_rdadr_i = adr;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (mem_rdack_o) begin
            got = 1;
            chk({tag, " rderr"}, mem_rderr_o, exp_err);
         end
         step();
      end
      if (!got) chk({tag, " rdack timeout"}, 0, 1);
      mem_rdreq_i = 1'b0;
   endtask

   task automatic write_beats(input string tag, input logic [3:0][31:0] d, input logic [3:0] mask);
      for (int k = 0; k < 4; k++) begin
         wr_valid_i = 1'b1;
         wr_data_i  = d[k];
         wr_mask_i  = mask;
         wr_last_i  = (k == 3);
         @(negedge clock);
         chk($sformatf("%s wr_ready b%0d", tag, k), wr_ready_o, 1);
         chk($sformatf("%s no ack in write b%0d", tag, k), {mem_wrack_o, mem_rdack_o}, 2'b00);
         step();
      end
      wr_valid_i = 1'b0;
      wr_last_i  = 1'b0;
   endtask

   // Expects the burst back-to-back starting two cycles after the ack, with rd_ready_i high.
   task automatic read_beats(input string tag, input logic [3:0][31:0] exp);
      @(negedge clock);
      chk({tag, " valid T+1"}, rd_valid_o, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clock);
         chk($sformatf("%s valid b%0d", tag, k), rd_valid_o, 1);
         chk($sformatf("%s data b%0d", tag, k), rd_data_o, exp[k]);
         chk($sformatf("%s last b%0d", tag, k), rd_last_o, (k == 3));
      end
      step();
      @(negedge clock);
      chk({tag, " valid after burst"}, rd_valid_o, 0);
      step();
   endtask

   logic [3:0][31:0] d40, d80, dmask, w0, d5, exp_lo, exp_hi, ones;
   logic             rerr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_run = 0; n_fail = 0;
      n_wrack = 0; n_rdack = 0; n_both = 0;
      d40[0] = 32'h11111111; d40[1] = 32'h22222222; d40[2] = 32'h33333333; d40[3] = 32'h44444444;
      for (int k = 0; k < 4; k++) begin
         ones[k]  = 32'h11111111;
         dmask[k] = 32'hAABBCCDD;
         d80[k]   = 32'h11BB11DD;
         w0[k]    = 32'h0000AAA0 + k;
         d5[k]    = 32'h55550000 + k;
      end
`ifdef MEM_SRAM_RESP_RANGECHK_EN
      rerr   = 1'b1;
      exp_lo = w0;
      exp_hi = '0;
`else
      rerr   = 1'b0;
      exp_lo[0] = d5[2]; exp_lo[1] = d5[3]; exp_lo[2] = w0[2]; exp_lo[3] = w0[3];
      exp_hi = d5;
`endif

      reset = 1'b1;
      mem_wrreq_i = 1'b1; mem_wradr_i = '0; mem_wrlst_i = 1'b0; mem_wrtid_i = 4'h3;
      wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_mask_i = '0; wr_data_i = '0;
      mem_rdreq_i = 1'b0; mem_rdadr_i = '0; mem_rdlst_i = 1'b0; mem_rdtid_i = 4'h5;
      rd_ready_i = 1'b1;
      step(); step();
      @(negedge clock);
      chk("rst wrack", mem_wrack_o, 0);
      chk("rst wrerr", mem_wrerr_o, 0);
      chk("rst rdack", mem_rdack_o, 0);
      chk("rst rderr", mem_rderr_o, 0);
      chk("rst wr_ready", wr_ready_o, 0);
      chk("rst rd_valid", rd_valid_o, 0);
      chk("rst rd_last", rd_last_o, 0);
      chk("rst rd_data", rd_data_o, 0);
      step();

      // Both requests at once: write wins, then read wins with a second write still pending.
      reset = 1'b0;
      mem_wrreq_i = 1'b1; mem_wradr_i = 32'h40;
      mem_rdreq_i = 1'b1; mem_rdadr_i = 32'h40;
      @(negedge clock);
      chk("arb first wrack", mem_wrack_o, 1);
      chk("arb first rdack", mem_rdack_o, 0);
      step();
      mem_wradr_i = 32'h80;
      write_beats("arb wr", d40, 4'hF);
      @(negedge clock);
      chk("arb second rdack", mem_rdack_o, 1);
      chk("arb second wrack", mem_wrack_o, 0);
      chk("arb wr_ready idle", wr_ready_o, 0);
      step();
      mem_rdreq_i = 1'b0;
      read_beats("arb rd", d40);
      chk("arb pending write acked", n_wrack, 2);
      mem_wrreq_i = 1'b0;
      write_beats("base80", ones, 4'hF);

      wait_wrack("mask wr", 32'h80, 1'b0);
      write_beats("mask wr", dmask, 4'b0101);
      wait_rdack("mask rd", 32'h80, 1'b0);
      read_beats("mask rd", d80);

      // Backpressure: six stalled cycles, then the full burst drains in order.
      rd_ready_i = 1'b0;
      wait_rdack("bp rd", 32'h40, 1'b0);
      @(negedge clock);
      chk("bp valid T+1", rd_valid_o, 0);
      for (int c = 2; c <= 6; c++) begin
         step();
         @(negedge clock);
         chk($sformatf("bp stall valid T+%0d", c), rd_valid_o, 1);
         chk($sformatf("bp stall data T+%0d", c), rd_data_o, d40[0]);
      end
      step();
      rd_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk($sformatf("bp valid b%0d", k), rd_valid_o, 1);
         chk($sformatf("bp data b%0d", k), rd_data_o, d40[k]);
         chk($sformatf("bp last b%0d", k), rd_last_o, (k == 3));
         step();
      end
      @(negedge clock);
      chk("bp drained", rd_valid_o, 0);
      step();

      wait_wrack("w0 wr", 32'h0, 1'b0);
      write_beats("w0 wr", w0, 4'hF);
      wait_wrack("edge wr", 32'hFF8, rerr);
      write_beats("edge wr", d5, 4'hF);
      wait_rdack("low rd", 32'h0, 1'b0);
      read_beats("low rd", exp_lo);
      wait_rdack("edge rd", 32'hFF8, rerr);
      read_beats("edge rd", exp_hi);

      // Reset after two SRAM reads have been issued.
      wait_rdack("rst rd", 32'h40, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("midrst rd_valid", rd_valid_o, 0);
      chk("midrst rd_last", rd_last_o, 0);
      chk("midrst rd_data", rd_data_o, 0);
      chk("midrst wr_ready", wr_ready_o, 0);
      chk("midrst acks", {mem_wrack_o, mem_rdack_o}, 2'b00);
      step();
      @(negedge clock);
      chk("midrst fifo empty", rd_valid_o, 0);
      step();
      wait_rdack("post rst rd", 32'h40, 1'b0);
      read_beats("post rst rd", d40);

      chk("acks never simultaneous", n_both, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
